lpc_record_serializer: RTL

LPC_RECORD_SERIALIZER -- requirements
Module: lpc_record_serializer

---
 rtl/lpc_record_serializer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/lpc_record_serializer.sv
// LPC capture record serializer: buffers 44-bit bus-capture records in a small
// FIFO and streams each one to a UART transmitter as an 11-digit uppercase hex
// line terminated by CR LF, with a byte-level ready/accept handshake.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | no record in flight; waiting for the FIFO to hold an entry
// LOAD       | pop FIFO head into the shadow register, byte index = 0
// OFFER      | current byte presented, waiting for tx_ready high
// WAIT_BUSY  | transmitter took the byte, waiting for tx_ready low
// WAIT_READY | byte accepted, waiting for tx_ready high before next byte

module lpc_record_serializer #(
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [43:0]           in_record,
    input  logic                  in_valid,
    input  logic                  tx_ready,
    output logic [7:0]            read_data,
    output logic                  read_clock_enable,
    output logic                  fifo_empty,
    output logic [DROP_WIDTH-1:0] drop_count
);

    localparam int              PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [3:0]      LAST_IDX = 4'd12;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        OFFER,
        WAIT_BUSY,
        WAIT_READY
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              tx_meta;
    logic              tx_sync;
    logic [43:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr_inc;
    logic              full;
    logic              push;
    logic              pop;
    logic              drop;
    logic [43:0]       shadow;
    logic [3:0]        byte_idx;

    // Byte idx of a record line: hex digits MSB first, then CR, then LF.
    function automatic logic [7:0] byte_of(input logic [43:0] rec, input logic [3:0] idx);
        logic [43:0] sh;
        logic [3:0]  nib;
        logic [7:0]  c;
        sh  = rec << {idx, 2'b00};
        nib = sh[43:40];
        if (idx < 4'd11) begin
            if (nib < 4'd10) c = {4'h3, nib};
            else             c = 8'h37 + {4'h0, nib};
        end else if (idx == 4'd11) begin
            c = 8'h0D;
        end else begin
            c = 8'h0A;
        end
        return c;
    endfunction

    assign wr_ptr_inc        = wr_ptr + PTR_ONE;
    assign fifo_empty        = (wr_ptr == rd_ptr) && !full;
    assign pop               = (state == LOAD) && !fifo_empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still take the write.
    assign push              = in_valid && (!full || pop);
    assign drop              = in_valid && full && !pop;
    assign read_clock_enable = (state == OFFER) || (state == WAIT_BUSY);

    // Two-flop synchronizer for the transmitter ready level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_meta <= 1'b0;
            tx_sync <= 1'b0;
        end else begin
            tx_meta <= tx_ready;
            tx_sync <= tx_meta;
        end
    end

    // Record FIFO storage, pointers and full flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_record;
                wr_ptr      <= wr_ptr_inc;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      full <= (wr_ptr_inc == rd_ptr);
            else if (pop && !push) full <= 1'b0;
        end
    end

    // Saturating count of records lost to a full FIFO.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_count <= '0;
        end else if (drop && (drop_count != '1)) begin
            drop_count <= drop_count + DROP_WIDTH'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!fifo_empty) state_nxt = LOAD;
            end
            LOAD: begin
                state_nxt = OFFER;
            end
            OFFER: begin
                if (byte_idx > LAST_IDX) state_nxt = IDLE;
                else if (tx_sync)        state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (byte_idx > LAST_IDX) state_nxt = IDLE;
                else if (!tx_sync)       state_nxt = WAIT_READY;
            end
            WAIT_READY: begin
                if (byte_idx > LAST_IDX) state_nxt = IDLE;
                else if (tx_sync)        state_nxt = (byte_idx == LAST_IDX) ? IDLE : OFFER;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shadow record, byte index and output byte; read_data only moves on OFFER entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow    <= '0;
            byte_idx  <= '0;
            read_data <= 8'h00;
        end else if (state == LOAD) begin
            shadow    <= mem[rd_ptr];
            byte_idx  <= 4'd0;
            read_data <= byte_of(mem[rd_ptr], 4'd0);
        end else if ((state == WAIT_READY) && (state_nxt == OFFER)) begin
            byte_idx  <= byte_idx + 4'd1;
            read_data <= byte_of(shadow, byte_idx + 4'd1);
        end
    end

endmodule
